avoid_planner: RTL and testbench

//  Parametrised obstacle-avoidance planner for the car.
//  - Debounces the two active-low IR side sensors.
//  - Applies hysteresis to the ultrasonic front distance.
//  - Runs a timed manoeuvre FSM (turn / reverse-then-escape) and drives the 2-bit motion command to the motor controller.
//  - Sampling is paced by a tick strobe from the system timebase instead of a second clock.

---
 rtl/avoid_planner.sv | 211 +++++++++++++++++++++
 tb/tb_avoid_planner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/avoid_planner.sv
// Obstacle-avoidance planner: debounced IR side flags, hysteretic front flag and a
// tick-paced manoeuvre FSM that issues the 2-bit motion command.
module avoid_planner #(
    parameter int DIST_W     = 20,
    parameter int BLOCK_NEAR = 200,
    parameter int BLOCK_FAR  = 260,
    parameter int DEB_N      = 3,
    parameter int TURN_TICKS = 2,
    parameter int BACK_TICKS = 4,
    parameter int MAX_TURN   = 16
) (
    input  logic              clk,
    input  logic              nCR,
    input  logic              tick,
    input  logic              left,
    input  logic              right,
    input  logic [DIST_W-1:0] dis,
    input  logic              dis_valid,
    output logic [1:0]        AvoidSignal,
    output logic              busy
);

    localparam int DEB_W   = $clog2(DEB_N + 1);
    localparam int CNT_MAX = (MAX_TURN > BACK_TICKS) ?
                             ((MAX_TURN > TURN_TICKS) ? MAX_TURN : TURN_TICKS) :
                             ((BACK_TICKS > TURN_TICKS) ? BACK_TICKS : TURN_TICKS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_N - 1);
    localparam logic [CNT_W-1:0]  TURN_LAST = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0]  BACK_LAST = CNT_W'(BACK_TICKS - 1);
    localparam logic [CNT_W-1:0]  MAXT_LAST = CNT_W'(MAX_TURN - 1);
    localparam logic [DIST_W-1:0] NEAR_V    = DIST_W'(BLOCK_NEAR);
    localparam logic [DIST_W-1:0] FAR_V     = DIST_W'(BLOCK_FAR);

    typedef enum logic [2:0] {
        ST_CRUISE  = 3'd0,
        ST_TURN_L  = 3'd1,
        ST_TURN_R  = 3'd2,
        ST_REVERSE = 3'd3,
        ST_ESC_L   = 3'd4,
        ST_ESC_R   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               pref_q, pref_d;
    logic               tick_q;
    logic               lflag_q, lflag_d, rflag_q, rflag_d, front_q, front_d;
    logic [DEB_W-1:0]   lcnt_q, lcnt_d, rcnt_q, rcnt_d;
    logic [DEB_W:0]     ldeb_s, rdeb_s;

    // Returns {next_flag, next_count} for one debounced side given the raw obstacle level.
    function automatic logic [DEB_W:0] deb_next(input logic raw, input logic flag,
                                                input logic [DEB_W-1:0] cnt);
        logic [DEB_W:0] res;
        if (raw != flag) begin
            if (cnt == DEB_LAST) begin
                res = {raw, {DEB_W{1'b0}}};
            end else begin
                res = {flag, cnt + {{(DEB_W-1){1'b0}}, 1'b1}};
            end
        end else begin
            res = {flag, {DEB_W{1'b0}}};
        end
        return res;
    endfunction

    function automatic logic [1:0] cmd_of(input state_t s);
        logic [1:0] c;
        case (s)
            ST_TURN_L, ST_ESC_L: c = 2'b10;
            ST_TURN_R, ST_ESC_R: c = 2'b01;
            ST_REVERSE:          c = 2'b11;
            default:             c = 2'b00;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input state_t s);
        logic ok;
        case (s)
            ST_CRUISE, ST_TURN_L, ST_TURN_R, ST_REVERSE, ST_ESC_L, ST_ESC_R: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign ldeb_s = deb_next(~left,  lflag_q, lcnt_q);
    assign rdeb_s = deb_next(~right, rflag_q, rcnt_q);

    // Sensor sampling: side debounce and front hysteresis, only on tick cycles.
    always_comb begin
        lflag_d = lflag_q;
        lcnt_d  = lcnt_q;
        rflag_d = rflag_q;
        rcnt_d  = rcnt_q;
        front_d = front_q;
        if (tick) begin
            {lflag_d, lcnt_d} = ldeb_s;
            {rflag_d, rcnt_d} = rdeb_s;
            // dis == 0 means no echo, so it never counts as a near obstacle.
            if (dis_valid && (dis != '0) && (dis < NEAR_V)) begin
                front_d = 1'b1;
            end else if (dis_valid && (dis >= FAR_V)) begin
                front_d = 1'b0;
            end else begin
                front_d = front_q;
            end
        end else begin
            front_d = front_q;
        end
    end

    // Manoeuvre FSM, evaluated one cycle after each sampling tick.
    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        tcnt_d  = tcnt_q;
        if (tick_q) begin
            case (state_q)
                ST_CRUISE: begin
                    if (front_q) begin
                        if (lflag_q && rflag_q) begin
                            state_d = ST_REVERSE;
                        end else if (lflag_q) begin
                            state_d = ST_TURN_R;
                        end else begin
                            state_d = ST_TURN_L;
                        end
                    end else begin
                        state_d = ST_CRUISE;
                    end
                end
                ST_TURN_L, ST_TURN_R: begin
                    if (tcnt_q < TURN_LAST) begin
                        state_d = state_q;
                    end else if (!front_q) begin
                        state_d = ST_CRUISE;
                    end else if ((lflag_q && rflag_q) || (tcnt_q >= MAXT_LAST)) begin
                        state_d = ST_REVERSE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_REVERSE: begin
                    if (tcnt_q >= BACK_LAST) begin
                        if (lflag_q && !rflag_q) begin
                            state_d = ST_ESC_R;
                        end else if (rflag_q && !lflag_q) begin
                            state_d = ST_ESC_L;
                        end else begin
                            state_d = pref_q ? ST_ESC_R : ST_ESC_L;
                            pref_d  = ~pref_q;
                        end
                    end else begin
                        state_d = ST_REVERSE;
                    end
                end
                ST_ESC_L, ST_ESC_R: begin
                    if (tcnt_q >= TURN_LAST) begin
                        state_d = ST_CRUISE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_CRUISE;
            endcase
        end else begin
            state_d = is_legal(state_q) ? state_q : ST_CRUISE;
        end

        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick_q && (tcnt_q != {CNT_W{1'b1}})) begin
            tcnt_d = tcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // State, flags, counters and registered command outputs.
    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            state_q     <= ST_CRUISE;
            tcnt_q      <= '0;
            pref_q      <= 1'b0;
            tick_q      <= 1'b0;
            lflag_q     <= 1'b0;
            rflag_q     <= 1'b0;
            front_q     <= 1'b0;
            lcnt_q      <= '0;
            rcnt_q      <= '0;
            AvoidSignal <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            pref_q      <= pref_d;
            tick_q      <= tick;
            lflag_q     <= lflag_d;
            rflag_q     <= rflag_d;
            front_q     <= front_d;
            lcnt_q      <= lcnt_d;
            rcnt_q      <= rcnt_d;
            AvoidSignal <= cmd_of(state_d);
            busy        <= (state_d != ST_CRUISE);
        end
    end

endmodule

// File: tb/tb_avoid_planner.sv
// Scoreboard bench for avoid_planner: a phase-level reference model predicts the
// command after every clock edge and a monitor compares it with the DUT.
module tb_avoid_planner;

    localparam int DIST_W     = 20;
    localparam int BLOCK_NEAR = 200;
    localparam int BLOCK_FAR  = 260;
    localparam int DEB_N      = 3;
    localparam int TURN_TICKS = 2;
    localparam int BACK_TICKS = 4;
    localparam int MAX_TURN   = 16;

    localparam int P_CRUISE = 0;
    localparam int P_TURN   = 1;
    localparam int P_BACK   = 2;
    localparam int P_ESC    = 3;

    logic              clk = 1'b0;
    logic              nCR, tick, left, right, dis_valid;
    logic [DIST_W-1:0] dis;
    logic [1:0]        AvoidSignal;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    // reference model state
    int   ph, mcnt, lrun, rrun;
    logic [1:0] dir;
    bit   pref, lf, rf, ff, pend;

    avoid_planner #(
        .DIST_W(DIST_W), .BLOCK_NEAR(BLOCK_NEAR), .BLOCK_FAR(BLOCK_FAR), .DEB_N(DEB_N),
        .TURN_TICKS(TURN_TICKS), .BACK_TICKS(BACK_TICKS), .MAX_TURN(MAX_TURN)
    ) dut (
        .clk(clk), .nCR(nCR), .tick(tick), .left(left), .right(right),
        .dis(dis), .dis_valid(dis_valid), .AvoidSignal(AvoidSignal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model_cmd();
        if (ph == P_CRUISE) return 2'b00;
        if (ph == P_BACK)   return 2'b11;
        return dir;
    endfunction

    task automatic model_reset();
        ph = P_CRUISE; mcnt = 0; lrun = 0; rrun = 0; dir = 2'b00;
        pref = 0; lf = 0; rf = 0; ff = 0; pend = 0;
    endtask

    task automatic model_eval();
        bit moved = 0;
        case (ph)
            P_CRUISE: if (ff) begin
                moved = 1;
                if (lf && rf) ph = P_BACK;
                else begin dir = lf ? 2'b01 : 2'b10; ph = P_TURN; end
            end
            P_TURN: if (mcnt >= TURN_TICKS - 1) begin
                if (!ff) begin ph = P_CRUISE; moved = 1; end
                else if ((lf && rf) || mcnt >= MAX_TURN - 1) begin ph = P_BACK; moved = 1; end
            end
            P_BACK: if (mcnt == BACK_TICKS - 1) begin
                moved = 1; ph = P_ESC;
                if (lf != rf) dir = lf ? 2'b01 : 2'b10;
                else begin dir = pref ? 2'b01 : 2'b10; pref = !pref; end
            end
            default: if (mcnt == TURN_TICKS - 1) begin ph = P_CRUISE; moved = 1; end
        endcase
        mcnt = moved ? 0 : mcnt + 1;
    endtask

    task automatic model_sample(input bit l, input bit r, input int d, input bit dv);
        if (!l != lf) begin
            lrun++;
            if (lrun == DEB_N) begin lf = !l; lrun = 0; end
        end else lrun = 0;
        if (!r != rf) begin
            rrun++;
            if (rrun == DEB_N) begin rf = !r; rrun = 0; end
        end else rrun = 0;
        if (dv && d != 0 && d < BLOCK_NEAR) ff = 1;
        else if (dv && d >= BLOCK_FAR) ff = 0;
    endtask

    // One clock: drive inputs at negedge, predict the post-edge output, wait for the edge.
    task automatic step(input bit rn, input bit t, input bit l, input bit r,
                        input int d, input bit dv);
        @(negedge clk);
        nCR = rn; tick = t; left = l; right = r; dis = DIST_W'(d); dis_valid = dv;
        if (!rn) model_reset();
        else begin
            if (pend) model_eval();
            if (t) model_sample(l, r, d, dv);
            pend = t;
        end
        exp_q.push_back({model_cmd(), ph != P_CRUISE});
        @(posedge clk);
    endtask

    task automatic check_now(input string name, input logic [1:0] ec, input logic eb);
        #1;
        checks++;
        if (AvoidSignal !== ec || busy !== eb) begin
            errors++;
            $display("FAIL %s: got cmd=%b busy=%b, expected cmd=%b busy=%b",
                     name, AvoidSignal, busy, ec, eb);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                if ({AvoidSignal, busy} !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got cmd=%b busy=%b, expected cmd=%b busy=%b",
                             $time, AvoidSignal, busy, mon_exp[2:1], mon_exp[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rl, rr, rt, rdv, rrn;
        int rd;
        model_reset();
        nCR = 1'b0; tick = 1'b0; left = 1'b1; right = 1'b1; dis = '0; dis_valid = 1'b0;

        // reset held with ticks toggling and a near distance
        for (int i = 0; i < 6; i++) step(0, i[0], 1, 1, 50, 1);
        check_now("reset_hold", 2'b00, 1'b0);
        repeat (3) step(1, 0, 1, 1, 50, 1);
        check_now("release_idle", 2'b00, 1'b0);

        // hysteresis
        repeat (2) step(1, 1, 1, 1, 300, 1);
        step(1, 1, 1, 1, 199, 1);
        step(1, 0, 1, 1, 199, 1);
        check_now("hyst_turn", 2'b10, 1'b1);
        repeat (3) step(1, 1, 1, 1, 230, 1);
        check_now("hyst_hold", 2'b10, 1'b1);
        step(1, 1, 1, 1, 260, 1);
        step(1, 0, 1, 1, 260, 1);
        check_now("hyst_clear", 2'b00, 1'b0);

        // debounce: a 2-tick glitch must not set the right flag
        repeat (2) step(1, 1, 1, 0, 300, 1);
        repeat (2) step(1, 1, 1, 1, 300, 1);
        step(1, 1, 1, 1, 100, 1);
        step(1, 0, 1, 1, 100, 1);
        check_now("debounce_glitch", 2'b10, 1'b1);
        repeat (4) step(1, 1, 1, 1, 300, 1);
        check_now("debounce_back", 2'b00, 1'b0);
        repeat (3) step(1, 1, 1, 0, 100, 1);
        step(1, 0, 1, 0, 100, 1);
        check_now("debounce_turn", 2'b10, 1'b1);
        repeat (6) step(1, 1, 1, 1, 300, 1);

        // both sides blocked: reverse, escape left, reverse, escape right
        repeat (4) step(1, 1, 0, 0, 300, 1);
        repeat (6) step(1, 1, 0, 0, 100, 1);
        check_now("escape_pref0", 2'b10, 1'b1);
        repeat (7) step(1, 1, 0, 0, 100, 1);
        check_now("escape_pref1", 2'b01, 1'b1);
        repeat (3) step(1, 1, 0, 0, 100, 1);
        check_now("mid_reverse", 2'b11, 1'b1);
        #2;
        nCR = 1'b0;
        model_reset();
        check_now("async_abort", 2'b00, 1'b0);
        repeat (2) step(0, 1, 0, 0, 100, 1);
        repeat (2) step(1, 0, 1, 1, 100, 1);
        check_now("no_stale", 2'b00, 1'b0);

        // turn timeout with front held blocked and only the right side blocked
        repeat (2) step(0, 0, 1, 1, 300, 1);
        repeat (17) step(1, 1, 1, 0, 100, 1);
        check_now("timeout_turn", 2'b10, 1'b1);
        step(1, 1, 1, 0, 100, 1);
        check_now("timeout_reverse", 2'b11, 1'b1);

        // randomized traffic
        rl = 1; rr = 1; rd = 300;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rl = !rl;
            if ($urandom_range(7) == 0) rr = !rr;
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(5))
                    0: rd = 0;
                    1: rd = 199;
                    2: rd = 200;
                    3: rd = 259;
                    4: rd = 260;
                    default: rd = int'($urandom_range(400));
                endcase
            end
            rt  = ($urandom_range(2) != 0);
            rdv = ($urandom_range(3) != 0);
            rrn = ($urandom_range(499) != 0);
            step(rrn, rt, rl, rr, rd, rdv);
        end

        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
